// File: rtl/calc_pkg.sv
// Shared opcode and FSM state constants for the sequential calculator core.
package calc_pkg;

  // Opcodes presented on the op input
  localparam logic [1:0] OP_SUMA  = 2'b00;
  localparam logic [1:0] OP_RESTA = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // Control FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_FIN  = 2'b10;

  // Multiply and divide are the multi-cycle operations (opcode MSB set)
  function automatic logic is_iterative(input logic [1:0] opcode);
    return opcode[1];
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Shift/accumulate datapath shared by the iterative multiply (mode=0) and
// restoring divide (mode=1). One partial product or quotient bit per step.
// After WIDTH steps: mul -> {out_hi,out_lo} = product;
//                    div -> out_hi = remainder, out_lo = quotient.
module mul_div_iter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  logic             mode_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  // Next-step value of the {hi,lo} pair for the selected operation
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    div_trial = {hi, lo[WIDTH-1]};
    div_diff  = div_trial - {1'b0, m};
    nxt_hi    = '0;
    nxt_lo    = '0;
    if (!mode_q) begin
      // add multiplicand when multiplier LSB is set, then shift the pair right
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      // trial subtraction fits: keep difference, quotient bit 1
      nxt_hi = div_diff[WIDTH-1:0];
      nxt_lo = {lo[WIDTH-2:0], 1'b1};
    end else begin
      // restore: keep the shifted partial remainder, quotient bit 0
      nxt_hi = div_trial[WIDTH-1:0];
      nxt_lo = {lo[WIDTH-2:0], 1'b0};
    end
  end

  // Operand capture on load, one iteration per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
    end else if (load) begin
      mode_q <= mode;
      m      <= mode ? b : a;
      hi     <= '0;
      lo     <= mode ? a : b;
    end else if (step) begin
      hi <= nxt_hi;
      lo <= nxt_lo;
    end
  end

  assign out_hi = hi;
  assign out_lo = lo;

endmodule

// File: rtl/menu_calculadora.sv
// Sequential calculator core: add/sub in one cycle, iterative mul/div,
// start/busy/done handshake with a result register updated only in FIN.
// busy and done are registered so that both fall on the same edge; the FSM
// is already back in IDLE during the done cycle, which lets a new start be
// accepted on the edge where done drops.
module menu_calculadora
  import calc_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [1:0]         state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt;
  logic               accept;
  logic               step;
  logic               div_zero;
  logic               iter_last;
  logic [WIDTH-1:0]   md_hi;
  logic [WIDTH-1:0]   md_lo;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] fin_result;
  logic               fin_err;

  // Handshake decode, add/sub arithmetic and final result selection
  always_comb begin
    accept    = (state == ST_IDLE) && start;
    div_zero  = (op_q == OP_DIV) && (b_q == '0);
    step      = (state == ST_CALC) && is_iterative(op_q) && !div_zero;
    iter_last = (cnt == CW'(WIDTH - 1));
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    fin_err   = div_zero;
    fin_result = '0;
    case (op_q)
      OP_SUMA:  fin_result = {{(WIDTH-1){1'b0}}, sum};
      OP_RESTA: fin_result = {{(WIDTH-1){diff[WIDTH]}}, diff};
      OP_MULT:  fin_result = {md_hi, md_lo};
      default:  fin_result = div_zero ? '1 : {md_hi, md_lo};
    endcase
  end

  // Control FSM, operand latches, iteration counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            cnt   <= '0;
            state <= ST_CALC;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_CALC: begin
          if (step) begin
            cnt <= cnt + 1'b1;
          end
          if (!step || iter_last) begin
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          done   <= 1'b1;
          result <= fin_result;
          err    <= fin_err;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mul_div_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .mode   (op[0]),
    .a      (a),
    .b      (b),
    .step   (step),
    .out_hi (md_hi),
    .out_lo (md_lo)
  );

endmodule
